nibble_serial_adder: RTL

Multi-nibble serial adder that sits directly upstream of the 4-bit ripple-carry stage and sequences wide operands through it one nibble per clock. Each cycle the stored carry is fed back into the next nibble, and the sum is assembled in a result register. The finished result is presented behind a valid/ready handshake. It lets the team add 4·NIBBLES-bit words using a single 4-bit adder core.

---
 rtl/nibble_adder_pkg.sv | 12 +
 rtl/rca4_core.sv | 23 ++
 rtl/nibble_serial_adder.sv | 134 +++++++++++++
 3 files changed

// File: rtl/nibble_adder_pkg.sv
// Shared constants and FSM state encoding for the nibble-serial adder.
package nibble_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rca4_core.sv
// 4-bit ripple-carry adder built from four full adders.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module rca4_core (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Serial W-bit adder: one nibble per clock through a single rca4_core.
// Latency: result valid NIBBLES cycles after acceptance; II = NIBBLES+2.
// Backpressure: holds result in DONE while out_ready is low; in_ready low when busy.
// OVF_FLAG_EN adds the out_ovf signed-overflow output.
module nibble_serial_adder
    import nibble_adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0]   in_a,
    input  logic [NIBBLE_W*NIBBLES-1:0]   in_b,
    input  logic                          in_cin,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0]   out_sum,
    output logic                          out_cout,
`ifdef OVF_FLAG_EN
    output logic                          out_ovf,
`endif
    output logic                          busy
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             carry_q, carry_d;
`ifdef OVF_FLAG_EN
    logic             ovf_q, ovf_d;
`endif

    int unsigned      nib_lsb;
    logic [3:0]       core_a, core_b, core_s;
    logic             core_cout;

    assign nib_lsb = int'(idx_q) * NIBBLE_W;
    assign core_a  = a_q[nib_lsb +: NIBBLE_W];
    assign core_b  = b_q[nib_lsb +: NIBBLE_W];

    // The single adder core is time-multiplexed across nibbles by idx_q.
    rca4_core u_core (
        .a    (core_a),
        .b    (core_b),
        .cin  (carry_q),
        .s    (core_s),
        .cout (core_cout)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
`ifdef OVF_FLAG_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_cin;
                    idx_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                sum_d[nib_lsb +: NIBBLE_W] = core_s;
                carry_d = core_cout;
                if (idx_q == IDX_LAST) begin
`ifdef OVF_FLAG_EN
                    // core_s[3] is bit W-1 of the sum on the last nibble.
                    ovf_d = (a_q[W-1] == b_q[W-1]) && (core_s[3] != a_q[W-1]);
`endif
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
`ifdef OVF_FLAG_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
`ifdef OVF_FLAG_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_sum   = sum_q;
    // After the last nibble the carry register holds the carry out of bit W-1.
    assign out_cout  = carry_q;
`ifdef OVF_FLAG_EN
    assign out_ovf   = ovf_q;
`endif

endmodule
